// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The stage drives the request side; memory answers with a one-cycle ack.
interface memory_access_stage_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage: runs loads/stores over a req/ack bus, stalls upstream while
// a transaction is open and aborts with a sticky error on timeout.
module memory_access_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbs_in,
  input  logic                  mrs_in,
  input  logic                  mws_in,
  input  logic [DATA_W-1:0]     ALUresult_in,
  input  logic [DATA_W-1:0]     writeData_in,
  input  logic                  ni_in,
  memory_access_stage_if.master mem,
  output logic                  wbs_out,
  output logic [DATA_W-1:0]     memData_out,
  output logic [DATA_W-1:0]     ALUresult_out,
  output logic                  ni_out,
  output logic                  stall_out,
  output logic                  err_out
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wbs_q;
  logic              ni_q;
  logic              abort_q;
  logic              err_q;
  logic              mem_op;

  assign mem_op        = mrs_in | mws_in;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign err_out       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wbs_q   <= 1'b0;
      ni_q    <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            addr_q  <= ALUresult_in;
            wdata_q <= writeData_in;
            wbs_q   <= wbs_in;
            ni_q    <= ni_in;
            we_q    <= mws_in;
            req_q   <= 1'b1;
            abort_q <= 1'b0;
            rdata_q <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // an ack on the final allowed cycle still completes normally
          if (mem.mem_ack) begin
            if (!we_q) rdata_q <= mem.mem_rdata;
            req_q <= 1'b0;
            cnt   <= '0;
            state <= DONE;
          end else if (cnt == LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wbs_out       = 1'b0;
    memData_out   = '0;
    ALUresult_out = '0;
    ni_out        = 1'b0;
    stall_out     = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          stall_out = 1'b1;
        end else begin
          wbs_out       = wbs_in;
          ALUresult_out = ALUresult_in;
          ni_out        = ni_in;
        end
      end
      BUSY: stall_out = 1'b1;
      DONE: begin
        ALUresult_out = addr_q;
        ni_out        = ni_q;
        wbs_out       = wbs_q & ~abort_q;
        memData_out   = (we_q | abort_q) ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: random ops, memory responder, and a
// scoreboard checked by an independent output monitor.
module tb_memory_access_stage;
  localparam int W = 16;
  localparam int T = 4;

  typedef struct {
    logic         wbs;
    logic [W-1:0] md;
    logic [W-1:0] alu;
    logic         ni;
    logic         err;
    int           stalls;
  } exp_t;

  typedef struct {
    int           d;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         we;
  } mreq_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wbs_in = 1'b0;
  logic         mrs_in = 1'b0;
  logic         mws_in = 1'b0;
  logic [W-1:0] alu_in = '0;
  logic [W-1:0] wd_in = '0;
  logic         ni_in = 1'b0;
  logic         wbs_out;
  logic [W-1:0] memData_out;
  logic [W-1:0] ALUresult_out;
  logic         ni_out;
  logic         stall_out;
  logic         err_out;
  logic         resp_ack = 1'b0;
  logic         inj_ack = 1'b0;
  logic [W-1:0] resp_rdata = '0;

  exp_t         sb[$];
  mreq_t        dq[$];
  logic [W-1:0] ref_mem[16];
  logic [W-1:0] bus_mem[16];
  logic         err_ref = 1'b0;
  bit           presenting = 1'b0;
  int           stall_cnt = 0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  memory_access_stage_if #(.DATA_W(W)) bus ();

  assign bus.mem_ack   = resp_ack | inj_ack;
  assign bus.mem_rdata = resp_rdata;

  memory_access_stage #(
    .DATA_W (W),
    .TIMEOUT(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wbs_in       (wbs_in),
    .mrs_in       (mrs_in),
    .mws_in       (mws_in),
    .ALUresult_in (alu_in),
    .writeData_in (wd_in),
    .ni_in        (ni_in),
    .mem          (bus),
    .wbs_out      (wbs_out),
    .memData_out  (memData_out),
    .ALUresult_out(ALUresult_out),
    .ni_out       (ni_out),
    .stall_out    (stall_out),
    .err_out      (err_out)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Present one instruction and hold it until the stage lets it go.
  task automatic issue(input bit mr, input bit mw, input bit wb,
                       input bit ni, input logic [W-1:0] a,
                       input logic [W-1:0] wd, input int d);
    exp_t  e;
    mreq_t m;
    bit    abort;
    int    n;
    @(posedge clk);
    #1;
    mrs_in = mr; mws_in = mw; wbs_in = wb;
    ni_in = ni; alu_in = a; wd_in = wd;
    presenting = 1'b1;
    e.alu = a;
    e.ni  = ni;
    if (mr || mw) begin
      abort = d > T;
      m.d = d; m.addr = a; m.wdata = wd; m.we = mw;
      dq.push_back(m);
      e.stalls = 1 + (abort ? T : d);
      e.wbs = wb && !abort;
      e.md  = (mw || abort) ? '0 : ref_mem[a[3:0]];
      if (mw && !abort) ref_mem[a[3:0]] = wd;
      if (abort) err_ref = 1'b1;
    end else begin
      e.stalls = 0;
      e.wbs = wb;
      e.md  = '0;
    end
    e.err = err_ref;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_out && n < 64);
    if (stall_out) flag("op_completion_timeout");
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    presenting = 1'b0;
    mrs_in = 1'b0; mws_in = 1'b0;
  endtask

  // Output monitor: bubbles while stalled, scoreboard pop otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !presenting) begin
        stall_cnt = 0;
      end else if (stall_out) begin
        stall_cnt++;
        chk("bubble_flags", 32'({wbs_out, ni_out}), 32'(0));
        chk("bubble_data", 32'(memData_out | ALUresult_out), 32'(0));
      end else if (sb.size() == 0) begin
        flag("unexpected_output");
      end else begin
        e = sb.pop_front();
        chk("wbs_out", 32'(wbs_out), 32'(e.wbs));
        chk("memData_out", 32'(memData_out), 32'(e.md));
        chk("ALUresult_out", 32'(ALUresult_out), 32'(e.alu));
        chk("ni_out", 32'(ni_out), 32'(e.ni));
        chk("err_out", 32'(err_out), 32'(e.err));
        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        stall_cnt = 0;
      end
    end
  end

  // Data memory: acks on the d-th request cycle, or never if d is large.
  initial begin
    mreq_t m;
    bit    act;
    int    cnt;
    act = 1'b0;
    cnt = 0;
    m.d = 0; m.addr = '0; m.wdata = '0; m.we = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack   = 1'b0;
      resp_rdata = W'($urandom);
      if (rst) begin
        act = 1'b0;
      end else if (!act && bus.mem_req) begin
        if (dq.size() == 0) begin
          flag("unexpected_mem_req");
        end else begin
          m = dq.pop_front();
          act = 1'b1;
          cnt = 1;
          chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
          chk("mem_we", 32'(bus.mem_we), 32'(m.we));
          if (m.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
        end
      end else if (act && !bus.mem_req) begin
        act = 1'b0;
      end else if (act) begin
        cnt++;
      end
      if (act && bus.mem_req && cnt == m.d) begin
        resp_ack = 1'b1;
        resp_rdata = bus_mem[m.addr[3:0]];
        if (m.we) bus_mem[m.addr[3:0]] = m.wdata;
      end
    end
  end

  initial begin
    int r;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = W'(i * 16'h0101);
      bus_mem[i] = W'(i * 16'h0101);
    end
    ref_mem[0] = 16'h1234;
    bus_mem[0] = 16'h1234;

    #12;
    chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
    chk("rst_err", 32'(err_out), 32'(0));
    chk("rst_stall", 32'(stall_out), 32'(0));
    @(posedge clk);
    #3;
    rst = 1'b0;

    issue(0, 0, 1, 1, 16'hABCD, 16'h0000, 0);
    issue(1, 0, 1, 0, 16'h0040, 16'h0000, 3);
    issue(0, 1, 0, 1, 16'h0010, 16'h5678, 1);
    issue(1, 0, 1, 1, 16'h0010, 16'h0000, T);
    issue(1, 0, 1, 0, 16'h0022, 16'h0000, 255);
    issue(0, 0, 1, 0, 16'h7777, 16'h0000, 0);
    issue(1, 0, 1, 0, 16'h0033, 16'h0000, 2);
    issue(1, 1, 1, 1, 16'h0033, 16'hBEEF, 1);
    issue(1, 0, 1, 0, 16'h0003, 16'h0000, 1);

    // reset while a load is waiting on an ack that never comes
    @(posedge clk);
    #1;
    mrs_in = 1'b1; mws_in = 1'b0; alu_in = 16'h0044;
    presenting = 1'b1;
    begin
      mreq_t m;
      m.d = 255; m.addr = 16'h0044; m.wdata = '0; m.we = 1'b0;
      dq.push_back(m);
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    presenting = 1'b0;
    mrs_in = 1'b0;
    #1;
    chk("rst_busy_req", 32'(bus.mem_req), 32'(0));
    chk("rst_busy_stall", 32'(stall_out), 32'(0));
    chk("rst_busy_err", 32'(err_out), 32'(0));
    sb.delete();
    dq.delete();
    err_ref = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    inj_ack = 1'b1;
    issue(0, 0, 0, 1, 16'h1111, 16'h0000, 0);
    chk("stray_ack_req", 32'(bus.mem_req), 32'(0));
    inj_ack = 1'b0;
    issue(0, 0, 1, 0, 16'h2222, 16'h0000, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom),
            (r == 0) ? 255 : $urandom_range(1, T));
    end

    idle();
    repeat (3) @(posedge clk);
    if (sb.size() != 0) flag("scoreboard_not_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory (MEM) stage of the 16-bit pipelined CPU. It sits between the Execute/Memory pipeline register and the MemoryWriteback pipeline register, and feeds the latter's wbs_in, memData_in, ALUresult_in and ni_in.
- It runs load/store transactions against the data memory over a req/ack handshake. While a transaction is outstanding it stalls upstream stages and inserts bubbles downstream.
- A timeout counter aborts hung transactions and raises a sticky error flag.

Parameters:
- DATA_W, 16, width of data and address buses.
- TIMEOUT, 16, maximum BUSY cycles waiting for mem_ack before abort (legal range 2..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wbs_in  in  1  writeback-enable from EX/MEM.
- mrs_in  in  1  memory-read (load) select.
- mws_in  in  1  memory-write (store) select.
- ALUresult_in  in  DATA_W  ALU result; used as the address for loads/stores.
- writeData_in  in  DATA_W  store data.
- ni_in  in  1  ni flag, carried to output unchanged.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  DATA_W  held address.
- mem_wdata  out  DATA_W  held store data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- wbs_out  out  1  to MEM/WB wbs_in.
- memData_out  out  DATA_W  to MEM/WB memData_in.
- ALUresult_out  out  DATA_W  to MEM/WB ALUresult_in.
- ni_out  out  1  to MEM/WB ni_in.
- stall_out  out  1  freezes PC, IF/ID, ID/EX and EX/MEM when high.
- err_out  out  1  sticky timeout error.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err_out=0, timeout counter=0.
  - All held registers go to 0.
  - Combinational outputs then follow the IDLE rules.
  - A reset mid-transaction drops mem_req the same instant; any later mem_ack is ignored.
- IDLE, no memory op (mrs_in=0 and mws_in=0), combinational pass-through:
  - wbs_out=wbs_in, ALUresult_out=ALUresult_in, ni_out=ni_in, memData_out=0, stall_out=0.
- IDLE, memory op (mrs_in or mws_in = 1):
  - stall_out=1; outputs are a bubble (wbs_out=0, ni_out=0, memData_out=0, ALUresult_out=0).
  - At the clock edge: capture ALUresult_in, writeData_in, wbs_in, ni_in and the op type; set mem_req=1 and mem_we=mws_in; go to BUSY.
  - If mrs_in=mws_in=1, the write wins: mem_we=1, and memData_out is 0 in DONE.
- BUSY:
  - stall_out=1, bubble outputs, mem_req held at 1, counter increments each cycle.
  - On mem_ack=1: capture mem_rdata (read) into rdata_q, mem_req→0, go to DONE.
  - If the counter reaches TIMEOUT-1 without ack: mem_req→0, err_out→1 (sticky until rst), abort flag set, go to DONE.
  - The counter clears on leaving BUSY.
- DONE (exactly one cycle):
  - stall_out=0; ALUresult_out=held address, ni_out=held ni.
  - Read: memData_out=rdata_q, wbs_out=held wbs.
  - Write: memData_out=0, wbs_out=held wbs.
  - Abort: wbs_out=0, memData_out=0, so no register-file write occurs.
  - EX/MEM inputs are ignored in this cycle. The MEM/WB register and upstream both advance at the end of the cycle; next state is IDLE.
- mem_ack outside BUSY is ignored.
- Latency: a memory op with ack in the first BUSY cycle costs 2 stall cycles; each additional ack-wait cycle adds 1. Non-memory ops cost 0.
- Store with wbs_in=1 is legal: ALUresult is forwarded in DONE.

Test Plan:
- Reset: assert rst mid-BUSY → mem_req=0, stall_out=0, err_out=0 immediately; a later mem_ack has no effect.
- Pass-through: mrs=mws=0, wbs_in=1, ALUresult_in=16'hABCD, ni_in=1 → same cycle: wbs_out=1, ALUresult_out=ABCD, ni_out=1, memData_out=0000, stall_out=0.
- Load, ack after 3 BUSY cycles: mrs_in=1, ALUresult_in=16'h0040, mem_rdata=16'h1234 → mem_addr=0040, mem_we=0, stall high for 4 cycles; DONE shows memData_out=1234, wbs_out=1, ALUresult_out=0040.
- Store, ack in first BUSY cycle: mws_in=1, ALUresult_in=16'h0010, writeData_in=16'h5678 → mem_we=1, mem_wdata=5678; stall high for exactly 2 cycles; DONE shows memData_out=0000.
- Timeout with TIMEOUT=4, no ack on a load → mem_req drops after 4 BUSY cycles; err_out=1 and stays 1; DONE shows wbs_out=0; the next non-memory op passes through normally.
- Back-to-back: load followed by load, with mrs_in and mws_in both 1 on the second op → second op starts only after DONE, and mem_we=1 for the conflict case.
